spi_miso_tx: RTL and testbench
==============================

# spi_miso_tx

SPI slave transmit path for the FPGA: it shifts 16-bit status/readback words from the FPGA to the ARM on `miso`, which is currently tied off. It shares the `ncs`/`spck` bus with the existing configuration-word receiver and uses the same SPI mode 0, MSB-first, 16-bit framing. All SPI inputs are oversampled on `pck0`. Words are queued by LF mode logic through a small FIFO with a valid/ready handshake.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of 2, ≥2.
- `WIDTH`, 16: word width; fixed at 16 to match frame length.

- `pck0` in 1: sole clock (LF PCK, 24 MHz); all logic on posedge.
- `nrst` in 1: reset, synchronous, active-low.
- `spck` in 1: SPI clock from ARM; asynchronous to `pck0`.
- `ncs` in 1: SPI chip select, active-low; asynchronous.
- `miso` out 1: serial data to ARM.
- `tx_data` in WIDTH: word to queue.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: FIFO can accept a word.
- `level` out clog2(DEPTH)+1: FIFO occupancy.
- `frame_done` out 1: one-cycle pulse; a full 16-bit frame completed.
- `frame_short` out 1: one-cycle pulse; `ncs` rose before 16 bits.
- `underrun` out 1: one-cycle pulse; frame started with empty FIFO.

## Operation
- `spck` and `ncs` each pass through a 2-FF synchronizer. A third register provides edge detection. Sync/edge FFs reset to idle values: `ncs`=1, `spck`=0.
- States:
  - RESYNC (reset state): waits for synchronized `ncs`=1, then goes to IDLE. A frame already in progress at reset release is ignored.
  - IDLE: on `ncs` fall:
    - FIFO non-empty: pop head into shift register.
    - FIFO empty: load 16'h0000 and pulse `underrun`.
    - Clear bit counter, go to SHIFT.
  - SHIFT:
    - Each `spck` rise increments the bit counter (0..16).
    - Each `spck` fall shifts the register left, inserting 0.
    - When the counter reaches 16, go to DRAIN.
  - DRAIN: extra clocks shift zeros; `miso` stays 0.
- On `ncs` rise from SHIFT or DRAIN, go to IDLE:
  - Counter = 16: pulse `frame_done`.
  - Counter < 16: pulse `frame_short`. The popped word is discarded, not re-queued.
- `miso` = shift[15] in SHIFT; 0 in RESYNC, IDLE and DRAIN.
- FIFO behaviour:
  - A push occurs when `tx_valid & tx_ready`.
  - `tx_ready` = !full, registered from the occupancy.
  - The pop decision uses the pre-push occupancy; there is no empty-FIFO bypass. A push and an underrun in the same cycle leave `level`=1.
  - A simultaneous push and pop with a non-empty FIFO leaves `level` unchanged.
  - Pointers wrap modulo DEPTH.
- `mosi` is not used here; the receiver path is unchanged.

## Timing
- Reset values: `miso`=0, `tx_ready`=0 while `nrst`=0 and 1 on the first cycle after release, `level`=0, all pulses 0, FIFO flushed, shift register 0.
- Reset mid-frame: the frame is abandoned. `miso` is 0 on the next edge and no `frame_*` pulse is generated. Operation resumes only after `ncs` is seen high.
- `ncs` fall → first bit on `miso`: 3 `pck0` cycles (2 sync + 1 register).
- `spck` fall → next bit on `miso`: 3 `pck0` cycles.
- Bus constraint: `spck` high and low phases each ≥4 `pck0` cycles, so `spck` ≤ 3 MHz. The ARM samples on `spck` rise.
- Pulse latency from the causing synchronized edge: 1 cycle. `level` updates 1 cycle after a push or pop.

## Structure
- Shared header `spi_defs.v`:
  - `SPI_WORD_BITS` = 16.
  - State encodings RESYNC / IDLE / SHIFT / DRAIN.
  - Command nibbles for the SPI command path.
- One sub-module `fifo_sync`:
  - Parameterized WIDTH/DEPTH, single clock, synchronous active-low reset.
  - Ports: push, pop, data, full, empty, level.
- Synchronizers and the FSM stay in `spi_miso_tx`.

## Test plan
- **Basic frame:** push 16'hA5C3; drop `ncs`; 16 `spck` cycles at 2 MHz; raise `ncs` → ARM samples 16'hA5C3 MSB first; `frame_done` pulses once; `level` goes 1→0.
- **Back-to-back:** push 16'h1234, 16'hFFFF, 16'h0001, 16'h8000 (FIFO full, `tx_ready`=0); a fifth `tx_valid` is ignored; four frames → words received in order, `level` ends 0.
- **Underrun:** with the FIFO empty, run a frame → `miso` all zeros; `underrun` pulses once; a push in the same cycle as the `ncs` fall yields `level`=1 and the next frame returns that word.
- **Short and long frames:**
  - Push 16'hBEEF; 7 clocks then raise `ncs` → `frame_short` pulse, word lost, `level`=0.
  - Push 16'hBEEF; 20 clocks → 16'hBEEF then four 0 bits; `frame_done` pulses.
- **Reset mid-frame:** assert `nrst` after 5 bits with `ncs` held low → `miso`=0, `level`=0, no pulses. Release `nrst` with `ncs` still low → no transmission. Raise `ncs`, then run a new frame → normal operation.

Source files
------------

// File: rtl/spi_miso_tx_pkg.sv
// Shared definitions for the SPI slave transmit path: frame length and FSM state encoding.
package spi_miso_tx_pkg;

    localparam int unsigned SPI_WORD_BITS = 16;
    localparam int unsigned BIT_CNT_W     = $clog2(SPI_WORD_BITS) + 1;

    typedef enum logic [1:0] {
        StResync = 2'd0,
        StIdle   = 2'd1,
        StShift  = 2'd2,
        StDrain  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/spi_miso_tx_fifo_sync.sv
// Single-clock word FIFO with occupancy count; head word is presented combinationally.
module spi_miso_tx_fifo_sync #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;

    logic             w_push;
    logic             w_pop;
    logic [LVL_W-1:0] w_level_d;

    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & (r_level != '0);

    always_comb begin
        w_level_d = r_level;
        if (w_push && !w_pop) begin
            w_level_d = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_d = r_level - LVL_W'(1);
        end
    end

    // Full reads 1 while in reset so producers hold off until the first released edge.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_d;
            r_full  <= (w_level_d == LVL_W'(DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/spi_miso_tx.sv
// SPI mode-0 slave transmitter: oversamples ncs/spck on pck0 and shifts queued
// 16-bit words out on miso, MSB first.
module spi_miso_tx
    import spi_miso_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = SPI_WORD_BITS,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             i_pck0,
    input  logic             i_nrst,
    input  logic             i_spck,
    input  logic             i_ncs,
    output logic             o_miso,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [LVL_W-1:0] o_level,
    output logic             o_frame_done,
    output logic             o_frame_short,
    output logic             o_underrun
);

    logic r_ncs_meta, r_ncs_sync, r_ncs_prev;
    logic r_spck_meta, r_spck_sync, r_spck_prev;

    always_ff @(posedge i_pck0) begin
        if (!i_nrst) begin
            r_ncs_meta  <= 1'b1;
            r_ncs_sync  <= 1'b1;
            r_ncs_prev  <= 1'b1;
            r_spck_meta <= 1'b0;
            r_spck_sync <= 1'b0;
            r_spck_prev <= 1'b0;
        end else begin
            r_ncs_meta  <= i_ncs;
            r_ncs_sync  <= r_ncs_meta;
            r_ncs_prev  <= r_ncs_sync;
            r_spck_meta <= i_spck;
            r_spck_sync <= r_spck_meta;
            r_spck_prev <= r_spck_sync;
        end
    end

    logic w_ncs_fall, w_ncs_rise, w_spck_rise, w_spck_fall;

    assign w_ncs_fall  = r_ncs_prev & ~r_ncs_sync;
    assign w_ncs_rise  = ~r_ncs_prev & r_ncs_sync;
    assign w_spck_rise = ~r_spck_prev & r_spck_sync;
    assign w_spck_fall = r_spck_prev & ~r_spck_sync;

    logic             w_fifo_push;
    logic             w_fifo_pop;
    logic [WIDTH-1:0] w_fifo_data;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    assign w_fifo_push = i_tx_valid & ~w_fifo_full;

    spi_miso_tx_fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_pck0),
        .i_nrst  (i_nrst),
        .i_push  (w_fifo_push),
        .i_data  (i_tx_data),
        .i_pop   (w_fifo_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (o_level)
    );

    assign o_tx_ready = ~w_fifo_full;

    tx_state_e            r_state, w_state_d;
    logic [WIDTH-1:0]     r_shift, w_shift_d;
    logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_d;
    logic [1:0]           r_warm;
    logic                 r_miso, w_miso_d;
    logic                 r_frame_done, w_frame_done_d;
    logic                 r_frame_short, w_frame_short_d;
    logic                 r_underrun, w_underrun_d;

    always_comb begin
        w_state_d       = r_state;
        w_shift_d       = r_shift;
        w_bit_cnt_d     = r_bit_cnt;
        w_fifo_pop      = 1'b0;
        w_frame_done_d  = 1'b0;
        w_frame_short_d = 1'b0;
        w_underrun_d    = 1'b0;

        unique case (r_state)
            StResync: begin
                // Synchronizer output is trusted only once two real samples have landed.
                if (r_warm[1] && r_ncs_sync) begin
                    w_state_d = StIdle;
                end
            end
            StIdle: begin
                if (w_ncs_fall) begin
                    if (!w_fifo_empty) begin
                        w_fifo_pop = 1'b1;
                        w_shift_d  = w_fifo_data;
                    end else begin
                        w_shift_d    = '0;
                        w_underrun_d = 1'b1;
                    end
                    w_bit_cnt_d = '0;
                    w_state_d   = StShift;
                end
            end
            StShift, StDrain: begin
                if (w_ncs_rise) begin
                    w_state_d = StIdle;
                    if (r_bit_cnt == BIT_CNT_W'(SPI_WORD_BITS)) begin
                        w_frame_done_d = 1'b1;
                    end else begin
                        w_frame_short_d = 1'b1;
                    end
                end else begin
                    if (w_spck_rise && (r_state == StShift)) begin
                        w_bit_cnt_d = r_bit_cnt + BIT_CNT_W'(1);
                        if (w_bit_cnt_d == BIT_CNT_W'(SPI_WORD_BITS)) begin
                            w_state_d = StDrain;
                        end
                    end
                    if (w_spck_fall) begin
                        w_shift_d = {r_shift[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: w_state_d = StResync;
        endcase

        w_miso_d = (w_state_d == StShift) ? w_shift_d[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge i_pck0) begin
        if (!i_nrst) begin
            r_state       <= StResync;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_warm        <= '0;
            r_miso        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_short <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_shift       <= w_shift_d;
            r_bit_cnt     <= w_bit_cnt_d;
            r_warm        <= (r_warm == 2'd3) ? r_warm : r_warm + 2'd1;
            r_miso        <= w_miso_d;
            r_frame_done  <= w_frame_done_d;
            r_frame_short <= w_frame_short_d;
            r_underrun    <= w_underrun_d;
        end
    end

    assign o_miso        = r_miso;
    assign o_frame_done  = r_frame_done;
    assign o_frame_short = r_frame_short;
    assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_spi_miso_tx.sv
// Directed bench for spi_miso_tx: plays the ARM master at 2 MHz-equivalent spck
// (6 pck0 cycles per phase) and checks received words, pulses and FIFO level.
module tb_spi_miso_tx;

    logic        pck0 = 1'b0;
    logic        nrst = 1'b0;
    logic        spck = 1'b0;
    logic        ncs  = 1'b1;
    logic [15:0] tx_data = 16'h0;
    logic        tx_valid = 1'b0;
    logic        miso;
    logic        tx_ready;
    logic [2:0]  level;
    logic        frame_done;
    logic        frame_short;
    logic        underrun;

    spi_miso_tx #(
        .DEPTH (4),
        .WIDTH (16)
    ) dut (
        .i_pck0        (pck0),
        .i_nrst        (nrst),
        .i_spck        (spck),
        .i_ncs         (ncs),
        .o_miso        (miso),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_level       (level),
        .o_frame_done  (frame_done),
        .o_frame_short (frame_short),
        .o_underrun    (underrun)
    );

    always #5 pck0 = ~pck0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_short  = 0;
    int n_under  = 0;

    // Counts high cycles, so a pulse longer than one cycle shows up as an extra count.
    always @(negedge pck0) begin
        if (frame_done)  n_done++;
        if (frame_short) n_short++;
        if (underrun)    n_under++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge pck0);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_cyc(1);
        tx_valid = 1'b0;
    endtask

    // ARM samples miso just before driving each spck rise.
    task automatic frame_body(input int nbits, input bit raise, output logic [31:0] rx);
        rx = '0;
        for (int b = 0; b < nbits; b++) begin
            rx   = {rx[30:0], miso};
            spck = 1'b1;
            wait_cyc(6);
            spck = 1'b0;
            wait_cyc(6);
        end
        if (raise) begin
            ncs = 1'b1;
            wait_cyc(6);
        end
    endtask

    task automatic run_frame(input int nbits, output logic [31:0] rx);
        ncs = 1'b0;
        wait_cyc(6);
        frame_body(nbits, 1'b1, rx);
    endtask

    logic [31:0] rx;
    int d0, s0, u0;
    logic [15:0] words [4];

    initial begin
        words[0] = 16'h1234;
        words[1] = 16'hFFFF;
        words[2] = 16'h0001;
        words[3] = 16'h8000;

        // Reset state
        wait_cyc(4);
        check_eq("rst_miso", 32'(miso), 32'h0);
        check_eq("rst_ready", 32'(tx_ready), 32'h0);
        check_eq("rst_level", 32'(level), 32'h0);
        check_eq("rst_pulses", 32'(n_done + n_short + n_under), 32'h0);
        nrst = 1'b1;
        wait_cyc(1);
        check_eq("rel_ready", 32'(tx_ready), 32'h1);
        wait_cyc(6);

        // Basic frame
        push(16'hA5C3);
        check_eq("basic_level1", 32'(level), 32'h1);
        d0 = n_done;
        run_frame(16, rx);
        check_eq("basic_word", rx, 32'h0000A5C3);
        check_eq("basic_done", 32'(n_done - d0), 32'h1);
        check_eq("basic_level0", 32'(level), 32'h0);

        // Back-to-back, FIFO full
        for (int i = 0; i < 4; i++) push(words[i]);
        check_eq("b2b_level4", 32'(level), 32'h4);
        check_eq("b2b_ready0", 32'(tx_ready), 32'h0);
        push(16'hDEAD);
        check_eq("b2b_fifth_ignored", 32'(level), 32'h4);
        d0 = n_done;
        for (int i = 0; i < 4; i++) begin
            run_frame(16, rx);
            check_eq($sformatf("b2b_word%0d", i), rx, {16'h0, words[i]});
        end
        check_eq("b2b_done", 32'(n_done - d0), 32'h4);
        check_eq("b2b_level_end", 32'(level), 32'h0);
        check_eq("b2b_ready_end", 32'(tx_ready), 32'h1);

        // Underrun with a push landing in the same cycle as the pop decision
        d0 = n_done; u0 = n_under;
        ncs = 1'b0;
        wait_cyc(2);
        tx_data  = 16'h5A5A;
        tx_valid = 1'b1;
        wait_cyc(1);
        tx_valid = 1'b0;
        check_eq("under_level1", 32'(level), 32'h1);
        wait_cyc(3);
        frame_body(16, 1'b1, rx);
        check_eq("under_zeros", rx, 32'h0);
        check_eq("under_pulse", 32'(n_under - u0), 32'h1);
        check_eq("under_done", 32'(n_done - d0), 32'h1);
        u0 = n_under;
        run_frame(16, rx);
        check_eq("under_next_word", rx, 32'h00005A5A);
        check_eq("under_no_pulse", 32'(n_under - u0), 32'h0);
        check_eq("under_level0", 32'(level), 32'h0);

        // Short frame: word is lost
        push(16'hBEEF);
        d0 = n_done; s0 = n_short;
        run_frame(7, rx);
        check_eq("short_bits", rx, 32'h5F);
        check_eq("short_pulse", 32'(n_short - s0), 32'h1);
        check_eq("short_no_done", 32'(n_done - d0), 32'h0);
        check_eq("short_level0", 32'(level), 32'h0);

        // Long frame: trailing zeros
        push(16'hBEEF);
        d0 = n_done; s0 = n_short;
        run_frame(20, rx);
        check_eq("long_bits", rx, 32'h000BEEF0);
        check_eq("long_done", 32'(n_done - d0), 32'h1);
        check_eq("long_no_short", 32'(n_short - s0), 32'h0);

        // Reset mid-frame
        d0 = n_done; s0 = n_short; u0 = n_under;
        push(16'h3C3C);
        push(16'h1111);
        ncs = 1'b0;
        wait_cyc(6);
        frame_body(5, 1'b0, rx);
        check_eq("midrst_partial", rx, 32'h7);
        nrst = 1'b0;
        wait_cyc(1);
        check_eq("midrst_miso", 32'(miso), 32'h0);
        check_eq("midrst_level", 32'(level), 32'h0);
        wait_cyc(3);
        nrst = 1'b1;
        wait_cyc(4);
        check_eq("midrst_ready", 32'(tx_ready), 32'h1);
        push(16'h7E81);
        frame_body(16, 1'b0, rx);
        check_eq("midrst_no_tx", rx, 32'h0);
        check_eq("midrst_level_held", 32'(level), 32'h1);
        ncs = 1'b1;
        wait_cyc(6);
        check_eq("midrst_no_pulses", 32'((n_done - d0) + (n_short - s0) + (n_under - u0)), 32'h0);
        run_frame(16, rx);
        check_eq("midrst_resume_word", rx, 32'h00007E81);
        check_eq("midrst_resume_done", 32'(n_done - d0), 32'h1);
        check_eq("midrst_resume_level", 32'(level), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
